// File: rtl/spi_flash_line_reader.sv
// rtl/spi_flash_line_reader.sv - SPI READ (0x03) line fill engine for the XIP cache
module spi_flash_line_reader #(
   parameter int LINE_SIZE = 16,
   parameter int ADDR_W    = 24
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   req,
   input  logic [ADDR_W-1:0]      addr,
   output logic                   busy,
   output logic                   done,
   output logic [LINE_SIZE*8-1:0] line_data,
   output logic                   sck,
   output logic                   ce_n,
   output logic                   mosi,
   input  logic                   miso
);

   localparam int LW = LINE_SIZE * 8;
   localparam int TW = 8 + ADDR_W;
   localparam int NB = TW + LW;
   localparam int CW = $clog2(NB);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;     // index of the bit currently on the wire
   logic            ph_q, ph_d;       // 0 = sck low phase, 1 = sck high phase
   logic [TW-1:0]   tx_q, tx_d;       // command + aligned address, MSB on mosi
   logic [LW-1:0]   rx_q, rx_d;       // serial stream, first byte ends up on top
   logic [LW-1:0]   line_q, line_d;
   logic [LW-1:0]   rx_full;
   logic            shifting;

   // Incoming stream including the bit being sampled at this edge
   always_comb begin
      rx_full = {rx_q[LW-2:0], miso};
   end

   // Next-state and datapath: each bit takes a low then a high phase; miso is
   // captured on the edge that closes the high phase
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      line_d  = line_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_CMD;
               cnt_d   = '0;
               ph_d    = 1'b0;
               tx_d    = {8'h03, addr & ~ADDR_W'(LINE_SIZE - 1)};
            end
         end
         S_CMD, S_ADDR, S_DATA: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d  = 1'b0;
               cnt_d = cnt_q + CW'(1);
               tx_d  = {tx_q[TW-2:0], 1'b0};
               if (state_q == S_DATA) begin
                  rx_d = rx_full;
               end
               if (state_q == S_CMD && cnt_q == CW'(7)) begin
                  state_d = S_ADDR;
               end
               if (state_q == S_ADDR && cnt_q == CW'(TW - 1)) begin
                  state_d = S_DATA;
               end
               if (state_q == S_DATA && cnt_q == CW'(NB - 1)) begin
                  state_d = S_DONE;
                  // First byte received lands in the lowest byte lane
                  for (int k = 0; k < LINE_SIZE; k++) begin
                     line_d[8*k +: 8] = rx_full[LW-8-8*k +: 8];
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ph_q    <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         line_q  <= line_d;
      end
   end

   // Pin and status decode from registered state only
   always_comb begin
      shifting  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
      sck       = shifting & ph_q;
      ce_n      = ~shifting;
      mosi      = ((state_q == S_CMD) || (state_q == S_ADDR)) & tx_q[TW-1];
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      line_data = line_q;
   end

endmodule

// File: tb/tb_spi_flash_line_reader.sv
// tb/tb_spi_flash_line_reader.sv - self-checking bench for spi_flash_line_reader
module tb_spi_flash_line_reader;

   localparam int LINE_SIZE = 16;
   localparam int ADDR_W    = 24;
   localparam int LW        = LINE_SIZE * 8;
   localparam int TW        = 8 + ADDR_W;
   localparam int NB        = TW + LW;

   logic              HCLK   = 1'b0;
   logic              HRESET = 1'b1;
   logic              req    = 1'b0;
   logic [ADDR_W-1:0] addr   = '0;
   logic              miso   = 1'b0;
   logic              busy, done, sck, ce_n, mosi;
   logic [LW-1:0]     line_data;

   spi_flash_line_reader #(.LINE_SIZE(LINE_SIZE), .ADDR_W(ADDR_W)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .req(req), .addr(addr),
      .busy(busy), .done(done), .line_data(line_data),
      .sck(sck), .ce_n(ce_n), .mosi(mosi), .miso(miso)
   );

   always #5 HCLK = ~HCLK;

   int total = 0;
   int bad   = 0;
   logic armed = 1'b0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Flash model: memory byte[i] = i[7:0]; shifts data out after each sck rise
   int          fb = 0;
   logic        f_prev = 1'b0;
   logic [7:0]  f_cmd = '0;
   logic [23:0] f_addr = '0;
   always @(negedge HCLK) begin : flash
      int j;
      logic [7:0] byte_v;
      if (ce_n) begin
         fb = 0;
         f_prev = 1'b0;
      end else begin
         if (sck && !f_prev) begin
            if (fb < 8) f_cmd = {f_cmd[6:0], mosi};
            else if (fb < TW) f_addr = {f_addr[22:0], mosi};
            else begin
               j = fb - TW;
               byte_v = 8'(f_addr + 24'(j / 8));
               miso <= byte_v[7 - (j % 8)];
            end
            fb++;
         end
         f_prev = sck;
      end
   end

   // Reference model: n = cycles since the accepting edge (0 = idle)
   int          n = 0;
   logic [LW-1:0] m_line = '0;
   logic [TW-1:0] m_tx = '0;
   logic [23:0]   m_base = '0;
   always @(posedge HCLK) begin
      if (HRESET) begin
         n = 0;
         m_line = '0;
      end else if (n == 0) begin
         if (req) begin
            n = 1;
            m_base = addr & ~24'(LINE_SIZE - 1);
            m_tx = {8'h03, m_base};
         end
      end else if (n == 2*NB + 1) begin
         n = 0;
      end else begin
         n++;
         if (n == 2*NB + 1)
            for (int k = 0; k < LINE_SIZE; k++) m_line[8*k +: 8] = 8'(m_base + 24'(k));
      end
   end

   // Per-cycle compare of all outputs against the model
   always @(negedge HCLK) begin
      logic [4:0] e;
      int i;
      if (armed) begin
         if (n == 0) e = 5'b10000;
         else if (n <= 2*NB) begin
            i = (n - 1) / 2;
            e = {1'b0, 1'((n - 1) % 2), (i < TW) ? m_tx[TW-1-i] : 1'b0, 1'b1, 1'b0};
         end else e = 5'b10011;
         chk("pins{ce_n,sck,mosi,busy,done}", LW'({ce_n, sck, mosi, busy, done}), LW'(e));
         chk("line_data", line_data, m_line);
      end
   end

   // Protocol monitor: ce_n low run length, gap between transfers, event counts
   int   done_cnt = 0, fall_cnt = 0, low_run = 0, high_run = 0;
   logic prev_ce = 1'b1;
   always @(negedge HCLK) begin
      if (armed) begin
         if (!ce_n) begin
            if (prev_ce) begin
               fall_cnt++;
               if (fall_cnt > 1) chk("ce_n_gap>=2", LW'(high_run >= 2), LW'(1));
               low_run = 0;
            end
            low_run++;
            high_run = 0;
         end else begin
            high_run++;
         end
         if (done) begin
            done_cnt++;
            chk("ce_n_low_cycles", LW'(low_run), LW'(2*NB));
         end
         prev_ce = ce_n;
      end
   end

   task automatic issue(input logic [ADDR_W-1:0] a);
      @(posedge HCLK); #2;
      req = 1'b1;
      addr = a;
      @(posedge HCLK); #2;
      req = 1'b0;
      addr = 24'hABCDEF;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int c = 1; c <= 1000; c++) begin
         @(negedge HCLK);
         if (done) begin
            lat = c;
            break;
         end
      end
      #1;
      if (lat < 0) chk("done_timeout", LW'(0), LW'(1));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, d0, f0, nd;
      logic [LW-1:0] lines [2];
      repeat (8) @(posedge HCLK);
      #2 HRESET = 1'b0;
      @(negedge HCLK);
      chk("reset_pins", LW'({ce_n, sck, mosi, busy, done}), LW'(5'b10000));
      chk("reset_line", line_data, '0);
      armed = 1'b1;

      issue(24'h000000);
      wait_done(lat);
      chk("lat_addr0", LW'(lat), LW'(321));
      chk("line_addr0", line_data, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("flash_cmd", LW'(f_cmd), LW'(8'h03));
      chk("flash_addr0", LW'(f_addr), LW'(24'h000000));

      issue(24'h000013);
      wait_done(lat);
      chk("lat_addr13", LW'(lat), LW'(321));
      chk("line_addr13", line_data, 128'h1F1E1D1C1B1A19181716151413121110);
      chk("flash_addr13", LW'(f_addr), LW'(24'h000010));

      @(posedge HCLK); #3;
      d0 = done_cnt; f0 = fall_cnt;
      issue(24'h000040);
      repeat (4) @(posedge HCLK);
      #2 req = 1'b1;
      @(posedge HCLK); #2 req = 1'b0;
      repeat (94) @(posedge HCLK);
      #2 req = 1'b1;
      @(posedge HCLK); #2 req = 1'b0;
      repeat (400) @(posedge HCLK);
      #3;
      chk("ignored_req_done_count", LW'(done_cnt - d0), LW'(1));
      chk("ignored_req_ce_falls", LW'(fall_cnt - f0), LW'(1));
      chk("line_addr40", line_data, 128'h4F4E4D4C4B4A49484746454443424140);

      @(posedge HCLK); #2;
      req = 1'b1; addr = 24'h000020;
      nd = 0;
      for (int c = 0; c < 700; c++) begin
         @(negedge HCLK);
         if (done) begin
            if (nd < 2) lines[nd] = line_data;
            nd++;
         end
      end
      @(posedge HCLK); #2 req = 1'b0;
      chk("held_req_done_count", LW'(nd), LW'(2));
      chk("held_line_first", lines[0], 128'h2F2E2D2C2B2A29282726252423222120);
      chk("held_line_second", lines[1], 128'h2F2E2D2C2B2A29282726252423222120);
      for (int c = 0; c < 1000 && busy; c++) @(negedge HCLK);
      chk("drain_idle", LW'(busy), LW'(0));

      issue(24'h000050);
      repeat (148) @(posedge HCLK);
      #2 HRESET = 1'b1;
      @(posedge HCLK); #2 HRESET = 1'b0;
      @(negedge HCLK);
      chk("abort_pins{ce_n,sck,busy,done}", LW'({ce_n, sck, busy, done}), LW'(4'b1000));
      chk("abort_line", line_data, '0);
      #1 d0 = done_cnt;
      repeat (400) @(posedge HCLK);
      #3;
      chk("abort_no_done", LW'(done_cnt - d0), LW'(0));
      issue(24'h000050);
      wait_done(lat);
      chk("lat_after_abort", LW'(lat), LW'(321));
      chk("line_after_abort", line_data, 128'h5F5E5D5C5B5A59585756555453525150);
      chk("flash_addr50", LW'(f_addr), LW'(24'h000050));

      repeat (4) @(posedge HCLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
